// File: rtl/rsa_pkg.sv
// Shared types and latency helpers for the modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, FIN} state_t;

  function automatic int lat_mul(input int w);
    return w + 1;
  endfunction

  // k = popcount(exp) in normal mode, EXP_WIDTH in constant-time mode
  function automatic int lat_total(input int w, input int ew, input int k);
    return 2 + (ew + k) * lat_mul(w);
  endfunction

endpackage

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle between the RSA control path and the exponentiator.
interface mod_exp_engine_if #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 2*WIDTH
);
  logic                 start;
  logic                 const_time;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exp;
  logic [WIDTH-1:0]     n;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [WIDTH-1:0]     result;

  modport master (output start, const_time, base, exp, n,
                  input  busy, done, err, result);
  modport slave  (input  start, const_time, base, exp, n,
                  output busy, done, err, result);
endinterface

// File: rtl/mod_exp_engine_mul.sv
// Serial interleaved modular multiplier: p = a*b mod n, WIDTH+1 cycles per product.
module mod_mul_serial #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH+1:0] r, a_q, n_q, t0, t1, t2;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;

  // r < n keeps 2r + a below 3n, so two subtractions fully reduce it
  always_comb begin
    t0 = (r << 1) + (b_q[WIDTH-1] ? a_q : '0);
    t1 = (t0 >= n_q) ? t0 - n_q : t0;
    t2 = (t1 >= n_q) ? t1 - n_q : t1;
  end

  // done/p are combinational so the caller can retire on the final iteration edge
  assign done = busy && (cnt == '0);
  assign p    = t2[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      r    <= '0;
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
    end else if (!busy) begin
      if (go) begin
        busy <= 1'b1;
        cnt  <= CW'(WIDTH-1);
        r    <= '0;
        a_q  <= {2'b00, a};
        b_q  <= b;
        n_q  <= {2'b00, n};
      end
    end else begin
      r   <= t2;
      b_q <= {b_q[WIDTH-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply exponentiator with optional constant-time dummy multiplies.
module mod_exp_engine #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 2*WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  mod_exp_engine_if.slave  bus
);
  import rsa_pkg::*;

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     base_q, n_q, acc, res_q, mul_b, mul_p;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IW-1:0]        idx;
  logic                 ct_q, err_q, done_q, mul_go, mul_busy, mul_done;
  logic                 bad, bit_q, last;

  assign bad   = (n_q < WIDTH'(2)) || (base_q >= n_q);
  assign bit_q = exp_q[idx];
  assign last  = (idx == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // a start coinciding with done is refused so the done cycle is always observed idle
  always_comb begin
    state_nxt = state;
    mul_go    = 1'b0;
    mul_b     = acc;
    case (state)
      IDLE:  if (bus.start && !done_q) state_nxt = CHECK;
      CHECK: state_nxt = bad ? FIN : SQR;
      SQR: begin
        mul_go = !mul_busy;
        if (mul_done) state_nxt = (bit_q || ct_q) ? MUL : (last ? FIN : SQR);
      end
      MUL: begin
        mul_go = !mul_busy;
        mul_b  = base_q;
        if (mul_done) state_nxt = last ? FIN : SQR;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q <= '0;
      n_q    <= '0;
      exp_q  <= '0;
      ct_q   <= 1'b0;
      acc    <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= (state == FIN);
      case (state)
        IDLE: if (state_nxt == CHECK) begin
          base_q <= bus.base;
          n_q    <= bus.n;
          exp_q  <= bus.exp;
          ct_q   <= bus.const_time;
          err_q  <= 1'b0;
        end
        CHECK: if (bad) begin
          err_q <= 1'b1;
          res_q <= '0;
        end else begin
          acc <= WIDTH'(1);
          idx <= IW'(EXP_WIDTH-1);
        end
        SQR: if (mul_done) begin
          acc <= mul_p;
          if (!(bit_q || ct_q) && !last) idx <= idx - 1'b1;
        end
        // dummy multiply on a 0-bit: product is discarded
        MUL: if (mul_done) begin
          if (bit_q) acc <= mul_p;
          if (!last) idx <= idx - 1'b1;
        end
        FIN:     res_q <= err_q ? '0 : acc;
        default: ;
      endcase
    end
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (mul_go),
    .a       (acc),
    .b       (mul_b),
    .n       (n_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .p       (mul_p)
  );

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = res_q;

endmodule
